// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for an NCO: settles the NCO pipeline, then steps the
// phase increment through n_steps frequencies, holding each for dwell enabled cycles.
module nco_sweep_ctrl #(
    parameter int APR        = 32,
    parameter int CW         = 16,
    parameter int SETTLE_CYC = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           stop,
    input  logic           loop_en,
    input  logic [APR-1:0] f_start,
    input  logic [APR-1:0] f_step,
    input  logic [CW-1:0]  n_steps,
    input  logic [CW-1:0]  dwell,
    input  logic           nco_out_valid,
    output logic [APR-1:0] phi_inc_o,
    output logic           nco_clken,
    output logic           busy,
    output logic           sample_valid,
    output logic [CW-1:0]  step_idx,
    output logic           done,
    output logic           cfg_err
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_DONE
    } state_t;

    state_t         state, state_n;

    logic [APR-1:0] f_start_q, f_step_q;
    logic [CW-1:0]  n_steps_q, dwell_q;
    logic [SW-1:0]  settle_cnt, settle_cnt_n;
    logic [CW-1:0]  dwell_cnt, dwell_cnt_n;
    logic [CW-1:0]  step_idx_n;
    logic [APR-1:0] phi_n;
    logic           cfg_err_n;
    logic           load_cfg;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed by the combinational block below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            f_start_q  <= '0;
            f_step_q   <= '0;
            n_steps_q  <= '0;
            dwell_q    <= '0;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            step_idx   <= '0;
            phi_inc_o  <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            dwell_cnt  <= dwell_cnt_n;
            step_idx   <= step_idx_n;
            phi_inc_o  <= phi_n;
            cfg_err    <= cfg_err_n;
            if (load_cfg) begin
                f_start_q <= f_start;
                f_step_q  <= f_step;
                n_steps_q <= n_steps;
                dwell_q   <= dwell;
            end
        end
    end

    // NOTE: every signal driven here gets a default first; a missing branch would
    // otherwise infer a latch.
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        dwell_cnt_n  = dwell_cnt;
        step_idx_n   = step_idx;
        phi_n        = phi_inc_o;
        cfg_err_n    = 1'b0;
        load_cfg     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // A simultaneous stop drops the start entirely, including cfg_err.
                if (start && !stop) begin
                    if (n_steps != '0 && dwell != '0) begin
                        load_cfg     = 1'b1;
                        phi_n        = f_start;
                        step_idx_n   = '0;
                        settle_cnt_n = '0;
                        state_n      = ST_SETTLE;
                    end else begin
                        cfg_err_n = 1'b1;
                    end
                end
            end

            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_n = '0;
                    dwell_cnt_n  = '0;
                    state_n      = ST_DWELL;
                end else begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end
            end

            ST_DWELL: begin
                if (dwell_cnt == dwell_q - 1'b1) begin
                    dwell_cnt_n = '0;
                    if (step_idx == n_steps_q - 1'b1) begin
                        // loop_en is deliberately the live input, not a latched copy.
                        if (loop_en) begin
                            phi_n      = f_start_q;
                            step_idx_n = '0;
                        end else begin
                            state_n = ST_DONE;
                        end
                    end else begin
                        // Phase-continuous step: modulo-2^APR add, no re-settle.
                        phi_n      = phi_inc_o + f_step_q;
                        step_idx_n = step_idx + 1'b1;
                    end
                end else begin
                    dwell_cnt_n = dwell_cnt + 1'b1;
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (stop && state != ST_IDLE) begin
            state_n      = ST_IDLE;
            settle_cnt_n = '0;
            dwell_cnt_n  = '0;
            step_idx_n   = '0;
            phi_n        = phi_inc_o;
        end
    end

    // Decoded from the state register, so reset clears them asynchronously.
    assign busy         = (state == ST_SETTLE) || (state == ST_DWELL);
    assign nco_clken    = busy;
    assign done         = (state == ST_DONE);
    assign sample_valid = nco_out_valid && (state == ST_DWELL);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed scenarios plus randomized sweeps
// compared against a per-cycle trace generated from the sweep rules.
module tb_nco_sweep_ctrl;

    localparam int APR        = 32;
    localparam int CW         = 16;
    localparam int SETTLE_CYC = 6;

    logic           clk           = 1'b0;
    logic           reset_n       = 1'b0;
    logic           start         = 1'b0;
    logic           stop          = 1'b0;
    logic           loop_en       = 1'b0;
    logic [APR-1:0] f_start       = '0;
    logic [APR-1:0] f_step        = '0;
    logic [CW-1:0]  n_steps       = '0;
    logic [CW-1:0]  dwell         = '0;
    logic           nco_out_valid = 1'b0;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken;
    logic           busy;
    logic           sample_valid;
    logic [CW-1:0]  step_idx;
    logic           done;
    logic           cfg_err;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        bit             busy;
        bit             done;
        logic [APR-1:0] phi;
        int             step;
        bit             chk_step;
        bit             in_dwell;
        bit             loop;
    } exp_t;

    nco_sweep_ctrl #(.APR(APR), .CW(CW), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .f_start      (f_start),
        .f_step       (f_step),
        .n_steps      (n_steps),
        .dwell        (dwell),
        .nco_out_valid(nco_out_valid),
        .phi_inc_o    (phi_inc_o),
        .nco_clken    (nco_clken),
        .busy         (busy),
        .sample_valid (sample_valid),
        .step_idx     (step_idx),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds the expected cycle-by-cycle trace of a whole sweep and walks the DUT
    // through it; with junk=1, config inputs and start are scrambled while busy.
    task automatic run_sweep(input logic [APR-1:0] fs, input logic [APR-1:0] fst,
                             input int n, input int d, input int rounds, input bit junk);
        exp_t           q[$];
        exp_t           e;
        logic [APR-1:0] last_phi;

        for (int c = 0; c < SETTLE_CYC; c++) begin
            e = '{busy: 1, done: 0, phi: fs, step: 0, chk_step: 1, in_dwell: 0,
                  loop: (rounds > 1)};
            q.push_back(e);
        end
        last_phi = fs;
        for (int r = 0; r < rounds; r++) begin
            for (int s = 0; s < n; s++) begin
                for (int c = 0; c < d; c++) begin
                    last_phi = fs + fst * APR'(s);
                    e = '{busy: 1, done: 0, phi: last_phi, step: s, chk_step: 1,
                          in_dwell: 1, loop: (r < rounds - 1)};
                    q.push_back(e);
                end
            end
        end
        e = '{busy: 0, done: 1, phi: last_phi, step: 0, chk_step: 0, in_dwell: 0, loop: 0};
        q.push_back(e);
        e = '{busy: 0, done: 0, phi: last_phi, step: 0, chk_step: 0, in_dwell: 0, loop: 0};
        q.push_back(e);

        f_start = fs;
        f_step  = fst;
        n_steps = CW'(n);
        dwell   = CW'(d);
        loop_en = (rounds > 1);
        start   = 1'b1;
        tick();
        start = 1'b0;

        foreach (q[i]) begin
            e             = q[i];
            loop_en       = e.loop;
            nco_out_valid = 1'($urandom_range(0, 1));
            if (junk) begin
                f_start = $urandom;
                f_step  = $urandom;
                n_steps = CW'($urandom);
                dwell   = CW'($urandom);
                start   = (i < q.size() - 1) && ($urandom_range(0, 3) == 0);
            end
            #1;
            check("busy", busy, e.busy);
            check("nco_clken", nco_clken, e.busy);
            check("done", done, e.done);
            check("phi_inc_o", phi_inc_o, e.phi);
            if (e.chk_step) check("step_idx", step_idx, CW'(e.step));
            check("sample_valid", sample_valid, nco_out_valid && e.in_dwell);
            check("cfg_err_busy", cfg_err, 1'b0);
            tick();
        end
        start         = 1'b0;
        loop_en       = 1'b0;
        nco_out_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_phi", phi_inc_o, 0);
        check("rst_busy", busy, 0);
        check("rst_clken", nco_clken, 0);
        check("rst_step", step_idx, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Reference sweep, then wrap-around in both directions
        run_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1, 1'b0);
        check("ref_final_phi", phi_inc_o, 32'h1200_0000);
        run_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 3, 1, 1'b0);
        check("wrap_up_phi", phi_inc_o, 32'h0000_0100);
        run_sweep(32'h0000_0080, 32'hFFFF_FF00, 2, 2, 1, 1'b0);
        check("wrap_dn_phi", phi_inc_o, 32'hFFFF_FF80);

        // Rejected starts
        n_steps = 0; dwell = 4; start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_err_n0", cfg_err, 1);
        check("cfg_err_n0_busy", busy, 0);
        check("cfg_err_n0_clken", nco_clken, 0);
        check("cfg_err_n0_phi", phi_inc_o, 32'hFFFF_FF80);
        tick();
        check("cfg_err_pulse", cfg_err, 0);
        n_steps = 3; dwell = 0; start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_err_d0", cfg_err, 1);
        check("cfg_err_d0_busy", busy, 0);
        tick();
        check("cfg_err_d0_idle", busy, 0);

        // Looping sweep: two rounds, loop_en dropped during the second
        run_sweep(32'h0200_0000, 32'h0010_0000, 2, 3, 2, 1'b0);

        // Stop during step 1
        f_start = 32'h1000_0000; f_step = 32'h0100_0000; n_steps = 3; dwell = 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (SETTLE_CYC + 4 + 1) tick();
        check("stop_pre_step", step_idx, 1);
        check("stop_pre_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_clken", nco_clken, 0);
        check("stop_done", done, 0);
        check("stop_phi", phi_inc_o, 32'h1100_0000);
        repeat (3) begin
            tick();
            check("stop_no_done", done, 0);
            check("stop_stays_idle", busy, 0);
        end

        // start together with stop in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 0);
        check("startstop_cfg_err", cfg_err, 0);
        tick();
        check("startstop_idle", busy, 0);

        // Randomized sweeps with scrambled inputs while busy
        for (int k = 0; k < 20; k++) begin
            run_sweep($urandom, $urandom, $urandom_range(1, 4), $urandom_range(1, 5),
                      $urandom_range(1, 2), 1'b1);
        end

        // sample_valid gating and asynchronous reset mid-DWELL
        f_start = 32'h0ABC_0000; f_step = 32'h0000_1000; n_steps = 3; dwell = 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        nco_out_valid = 1'b1;
        #1;
        check("settle_sample_valid", sample_valid, 0);
        repeat (SETTLE_CYC) tick();
        check("dwell_sample_valid", sample_valid, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_phi", phi_inc_o, 0);
        check("arst_busy", busy, 0);
        check("arst_clken", nco_clken, 0);
        check("arst_sample_valid", sample_valid, 0);
        check("arst_step", step_idx, 0);
        check("arst_done", done, 0);
        check("arst_cfg_err", cfg_err, 0);
        tick();
        reset_n = 1'b1;
        nco_out_valid = 1'b0;
        repeat (3) begin
            tick();
            check("post_rst_idle", busy, 0);
            check("post_rst_done", done, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
